dff_pipe: RTL

- Parametrised successor to the single-bit flop: a WIDTH-bit, DEPTH-stage register pipeline with a valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count.
- Used wherever the design needs configurable register retiming on a streaming path with backpressure.
- Each stage can be built in reset or no-reset data mode, chosen by parameter.

---
 rtl/dff_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with a valid/ready handshake, bubble
// collapsing, synchronous flush and a registered count of occupied stages.
module dff_pipe #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 3,
  parameter bit               DATA_RESET = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned CW = $clog2(DEPTH+1);

  if (DEPTH < 1) begin : g_depth_check
    $error("dff_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0]            valid_q, valid_d, up_valid, rdy;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, up_data;
  logic [CW-1:0]               count_q, count_d;

  // Ready chain walked from the output end with a running term so no bit of rdy reads another.
  always_comb begin
    logic chain;
    chain = out_ready;
    rdy   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      chain              = !valid_q[DEPTH-1-k] || chain;
      rdy[DEPTH-1-k]     = chain;
    end
  end

  always_comb begin
    up_valid    = '0;
    up_data     = '0;
    up_valid[0] = in_valid && !flush;
    up_data[0]  = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rdy[i]) valid_d[i] = up_valid[i];
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // With DATA_RESET=0 the reset term folds away and the data flops carry no reset.
  always_ff @(posedge clk) begin
    if (DATA_RESET && !reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
    end else if (reset_n && !flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rdy[i] && up_valid[i]) data_q[i] <= up_data[i];
      end
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule
